// File: rtl/interrupt_controller_if.sv
// Pipeline/COP0 side bundle of the 3-level nested interrupt controller.
// The slave modport is the controller; the master modport is the pipeline.
interface interrupt_controller_if;
   logic [2:0]  irq;
   logic [31:0] pc_in;
   logic        int_ack;
   logic        eret;
   logic        mtc0_we;
   logic [4:0]  cop0_addr;
   logic [31:0] cop0_wdata;
   logic        int_req;
   logic [31:0] int_vector;
   logic [31:0] epc;
   logic [31:0] cop0_rdata;
   logic [2:0]  in_service;
   logic        ie;

   modport slave (
      input  irq, pc_in, int_ack, eret, mtc0_we, cop0_addr, cop0_wdata,
      output int_req, int_vector, epc, cop0_rdata, in_service, ie
   );

   modport master (
      output irq, pc_in, int_ack, eret, mtc0_we, cop0_addr, cop0_wdata,
      input  int_req, int_vector, epc, cop0_rdata, in_service, ie
   );
endinterface

// File: rtl/interrupt_controller.sv
// Three-level priority interrupt controller with edge-triggered lines,
// nesting by priority, a 3-deep EPC stack and Status/Cause/EPC COP0 registers.
module interrupt_controller (
   input  logic                    clk,
   input  logic                    rst,
   interrupt_controller_if.slave   bus
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_irq_q;
   logic [2:0]  r_pending;
   logic [2:0]  r_im;
   logic [2:0]  r_in_service;
   logic        r_ie;
   logic        r_int_req;
   logic [1:0]  r_sel;
   logic [1:0]  r_sp;
   logic [31:0] r_int_vector;
   logic [31:0] r_stack [0:2];

   logic [2:0]  w_edge;
   logic [2:0]  w_above;
   logic [2:0]  w_eligible;
   logic [2:0]  w_pend_clr;
   logic [2:0]  w_svc_clr;
   logic [1:0]  w_sel_nxt;
   logic [1:0]  w_top;
   logic        w_take;
   logic        w_ack;
   logic        w_pop;
   logic [31:0] w_epc;
   logic [31:0] w_rdata;

   function automatic logic [1:0] f_hi_idx(input logic [2:0] v);
      logic [1:0] idx;
      if (v[2]) idx = 2'd2;
      else if (v[1]) idx = 2'd1;
      else idx = 2'd0;
      return idx;
   endfunction

   function automatic logic [2:0] f_onehot(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

   always_comb begin
      w_edge = bus.irq & ~r_irq_q;
      // Only levels strictly above the highest one in service may nest
      if (r_in_service[2]) w_above = 3'b000;
      else if (r_in_service[1]) w_above = 3'b100;
      else if (r_in_service[0]) w_above = 3'b110;
      else w_above = 3'b111;
      w_eligible = r_pending & r_im & {3{r_ie}} & w_above;
      w_sel_nxt  = f_hi_idx(w_eligible);
      w_top      = r_sp - 2'd1;
      w_pop      = (r_state == ST_IDLE) && bus.eret && (r_in_service != 3'b000) && (r_sp != 2'd0);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_ack       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_eligible != 3'b000) begin
               w_state_nxt = ST_REQ;
               w_take      = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.int_ack) begin
               w_state_nxt = ST_IDLE;
               w_ack       = 1'b1;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_pend_clr = w_ack ? f_onehot(r_sel) : 3'b000;
      w_svc_clr  = w_pop ? f_onehot(f_hi_idx(r_in_service)) : 3'b000;
   end

   always_comb begin
      if (r_sp == 2'd0) w_epc = 32'd0;
      else w_epc = r_stack[w_top];
      case (bus.cop0_addr)
         5'd12:   w_rdata = {21'd0, r_im, 7'd0, r_ie};
         5'd13:   w_rdata = {21'd0, r_pending, 5'd0, r_in_service};
         5'd14:   w_rdata = w_epc;
         default: w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_q      <= 3'b000;
         r_pending    <= 3'b000;
         r_im         <= 3'b000;
         r_ie         <= 1'b0;
         r_in_service <= 3'b000;
         r_sel        <= 2'd0;
         r_int_req    <= 1'b0;
         r_int_vector <= 32'd0;
      end else begin
         r_irq_q   <= bus.irq;
         // A new edge in the ack cycle wins over the ack's clear
         r_pending <= (r_pending & ~w_pend_clr) | w_edge;
         r_int_req <= (w_state_nxt == ST_REQ);
         if (w_take) begin
            r_sel        <= w_sel_nxt;
            r_int_vector <= 32'h0000_2000 + {24'd0, w_sel_nxt, 6'd0};
         end
         if (w_ack) r_in_service <= r_in_service | f_onehot(r_sel);
         else       r_in_service <= r_in_service & ~w_svc_clr;
         if (bus.mtc0_we && (bus.cop0_addr == 5'd12)) begin
            r_ie <= bus.cop0_wdata[0];
            r_im <= bus.cop0_wdata[10:8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) r_stack[k] <= 32'd0;
         r_sp <= 2'd0;
      end else if (w_ack && (r_sp != 2'd3)) begin
         r_stack[r_sp] <= bus.pc_in;
         r_sp          <= r_sp + 2'd1;
      end else if (w_pop) begin
         r_stack[w_top] <= 32'd0;
         r_sp           <= r_sp - 2'd1;
      end else if (bus.mtc0_we && (bus.cop0_addr == 5'd14) && (r_sp != 2'd0)) begin
         r_stack[w_top] <= bus.cop0_wdata;
      end
   end

   assign bus.int_req    = r_int_req;
   assign bus.int_vector = r_int_vector;
   assign bus.epc        = w_epc;
   assign bus.cop0_rdata = w_rdata;
   assign bus.in_service = r_in_service;
   assign bus.ie         = r_ie;
endmodule
